// File: rtl/matrix_pop_ctrl_if.sv
// Handshake bundle between matrix_pop_ctrl, its matrix FIFO and the downstream consumer.
// err is present only when MATRIX_POP_TIMEOUT_EN is defined.
interface matrix_pop_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  start;
    logic [3:0]            N;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  pop;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;
    logic [3:0]            count;
`ifdef MATRIX_POP_TIMEOUT_EN
    logic                  err;
`endif

    modport master (
        output start, N, fifo_empty, fifo_data, out_ready,
`ifdef MATRIX_POP_TIMEOUT_EN
        input  err,
`endif
        input  pop, out_data, out_valid, busy, done, count
    );

    modport slave (
        input  start, N, fifo_empty, fifo_data, out_ready,
`ifdef MATRIX_POP_TIMEOUT_EN
        output err,
`endif
        output pop, out_data, out_valid, busy, done, count
    );
endinterface

// File: rtl/matrix_pop_ctrl.sv
// Reads one N-element vector from the matrix FIFO and hands it downstream element by element.
// Optional empty-FIFO timeout with err pulse when MATRIX_POP_TIMEOUT_EN is defined.
module matrix_pop_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TO_CYCLES  = 255
) (
    input  logic             clk,
    input  logic             rst,
    matrix_pop_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        CAPT,
        OUT,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      n_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_inc_c;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  accept_c;
    logic                  handshake_c;

`ifdef MATRIX_POP_TIMEOUT_EN
    localparam int unsigned TO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_c;
    logic            err_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept_c    = 1'b0;
        handshake_c = 1'b0;
        count_inc_c = count_q + CNT_W'(1);
`ifdef MATRIX_POP_TIMEOUT_EN
        timeout_c   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept_c   = 1'b1;
                    state_next = (bus.N == '0) ? DONE : POP;
                end
            end
            POP: begin
                if (!bus.fifo_empty) begin
                    state_next = CAPT;
                end
`ifdef MATRIX_POP_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TO_CYCLES - 1)) begin
                    timeout_c  = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            CAPT: state_next = OUT;
            OUT: begin
                if (bus.out_ready) begin
                    handshake_c = 1'b1;
                    state_next  = (count_inc_c == n_q) ? DONE : POP;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q         <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            busy_q      <= (state_next != IDLE);
            done_q      <= (state_next == DONE);
            out_valid_q <= (state_next == OUT);
            if (accept_c) begin
                n_q     <= bus.N;
                count_q <= '0;
            end else if (handshake_c) begin
                count_q <= count_inc_c;
            end
            if (state == CAPT) begin
                out_data_q <= bus.fifo_data;
            end
        end
    end

`ifdef MATRIX_POP_TIMEOUT_EN
    // Counts consecutive empty cycles spent in POP; cleared by any other cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= timeout_c;
            if ((state == POP) && bus.fifo_empty && !timeout_c) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    assign bus.err = err_q;
`endif

    // The FIFO read strobe must be combinational so the read lands in the same cycle.
    assign bus.pop       = (state == POP) && !bus.fifo_empty;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.count     = count_q;
endmodule
